// File: rtl/mat_mul_pkg.sv
// rtl/mat_mul_pkg.sv - shared types and defaults for the mat_mul scheduler
// Provides default element widths and matrix dimension, the scheduler state
// enum and flat matrix typedefs sized from the defaults.
package mat_mul_pkg;

    localparam int W_IN_DEF  = 8;
    localparam int W_OUT_DEF = 32;
    localparam int N_DEF     = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    typedef logic [N_DEF*N_DEF*W_IN_DEF-1:0]  mat_in_t;
    typedef logic [N_DEF*N_DEF*W_OUT_DEF-1:0] mat_out_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with occupancy count
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   push, push_data      write strobe and data (accepted when full if a pop
//                        happens in the same cycle)
//   pop, pop_data        read strobe and head-of-queue data (first-word fall-through)
//   full, empty, count   status and current occupancy
module sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    // When full, a same-cycle pop frees the slot being written; the head is
    // read combinationally before the write lands at the clock edge.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mat_mul_sched.sv
// rtl/mat_mul_sched.sv - round-robin scheduler sharing one mat_mul pipeline
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   req_valid/req_ready             per-requester job handshake (ready one-hot or zero)
//   req_mode, req_matrix_1/2        per-requester job mode and flat signed operands
//   mm_cen, mm_valid_in, mm_mode,
//   mm_matrix_1/2                   issue side of the mat_mul pipeline
//   mm_valid_out, mm_result         result side of the mat_mul pipeline
//   rsp_valid/rsp_ready, rsp_id,
//   rsp_result                      tagged result stream to the consumer
//   flush_req, flush_done           drain request and one-cycle completion pulse
//   inflight                        jobs issued but not yet returned
module mat_mul_sched
    import mat_mul_pkg::*;
#(
    parameter int W_IN         = W_IN_DEF,
    parameter int W_OUT        = W_OUT_DEF,
    parameter int N            = N_DEF,
    parameter int NUM_REQ      = 2,
    parameter int MAX_INFLIGHT = 8,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_mode,
    input  logic [NUM_REQ*N*N*W_IN-1:0]    req_matrix_1,
    input  logic [NUM_REQ*N*N*W_IN-1:0]    req_matrix_2,
    output logic                           mm_cen,
    output logic                           mm_valid_in,
    output logic                           mm_mode,
    output logic [N*N*W_IN-1:0]            mm_matrix_1,
    output logic [N*N*W_IN-1:0]            mm_matrix_2,
    input  logic                           mm_valid_out,
    input  logic [N*N*W_OUT-1:0]           mm_result,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [N*N*W_OUT-1:0]           rsp_result,
    input  logic                           flush_req,
    output logic                           flush_done,
    output logic [$clog2(MAX_INFLIGHT):0]  inflight
);

    localparam int MW = N*N*W_IN;
    localparam int CW = $clog2(MAX_INFLIGHT) + 1;

    sched_state_t        state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     rr_next;
    logic                win_found;
    logic                stall;
    logic                pop;
    logic                grant;
    logic                drained;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [2*NUM_REQ-1:0] dbl_valid;
    logic [NUM_REQ-1:0]  rot_valid;
    logic [ID_W:0]       idx_sum;

    // Back-pressure freezes the whole pipeline while a result is waiting.
    assign stall      = mm_valid_out & ~rsp_ready;
    assign mm_cen     = ~stall;
    assign pop        = mm_valid_out & rsp_ready;
    assign rsp_valid  = mm_valid_out;
    assign rsp_result = mm_result;
    assign inflight   = fifo_count;

    // Rotate the valids so bit 0 is the requester at the RR pointer, then take
    // the lowest set bit and map it back to an absolute requester index.
    assign dbl_valid = {req_valid, req_valid} >> rr_ptr;
    assign rot_valid = dbl_valid[NUM_REQ-1:0];

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx_sum   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_valid[i]) begin
                win_found = 1'b1;
                idx_sum   = {1'b0, rr_ptr} + (ID_W+1)'(i);
                if (idx_sum >= (ID_W+1)'(NUM_REQ)) begin
                    idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
                end
                win_id = idx_sum[ID_W-1:0];
            end
        end
    end

    // A full FIFO still accepts when the head retires this cycle. The flush
    // request itself already blocks issue so nothing slips in behind it.
    assign grant = rstn & (state == RUN) & ~flush_req & ~stall
                 & (~fifo_full | pop) & win_found;

    assign rr_next     = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
    assign req_ready   = grant ? (NUM_REQ'(1) << win_id) : '0;
    assign mm_valid_in = grant;
    assign mm_mode     = grant & req_mode[win_id];
    assign mm_matrix_1 = grant ? req_matrix_1[win_id*MW +: MW] : '0;
    assign mm_matrix_2 = grant ? req_matrix_2[win_id*MW +: MW] : '0;

    // Empty now, or the last job retires this cycle.
    assign drained = (fifo_count == '0) || ((fifo_count == CW'(1)) && pop);

    sync_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_id_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (grant),
        .push_data (win_id),
        .pop       (pop),
        .pop_data  (rsp_id),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= RUN;
            rr_ptr     <= '0;
            flush_done <= 1'b0;
        end else begin
            if (grant) begin
                rr_ptr <= rr_next;
            end
            flush_done <= 1'b0;
            case (state)
                RUN: begin
                    if (flush_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    a_result_has_owner: assert property (
        @(posedge clk) disable iff (!rstn) mm_valid_out |-> !fifo_empty
    );

endmodule

// File: doc/mat_mul_sched.md
Name: mat_mul_sched

Overview:
- Shares one `mat_mul` pipeline between NUM_REQ requesters, using round-robin arbitration.
- Issues one job per cycle into the pipeline and tracks in-flight jobs with an ID FIFO.
- Routes each result back tagged with its requester ID; back-pressure is applied by dropping `mm_cen`.
- Sits between requester-side DMA/control logic and the `mat_mul` instance; it also supplies a drain/flush for mode changes.

Parameters:
- W_IN, 8, input element width
- W_OUT, 32, result element width
- N, 8, matrix dimension
- NUM_REQ, 2, number of requesters (2..4)
- MAX_INFLIGHT, 8, ID FIFO depth; power of 2, must be ≥ mat_mul latency for full throughput
- ID_W, $clog2(NUM_REQ), requester ID width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester job valid
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
- req_mode  in  NUM_REQ  per-requester mat_mul mode
- req_matrix_1  in  NUM_REQ*N*N*W_IN  per-requester operand A, signed
- req_matrix_2  in  NUM_REQ*N*N*W_IN  per-requester operand B, signed
- mm_cen  out  1  pipeline clock enable to mat_mul
- mm_valid_in  out  1  job strobe to mat_mul
- mm_mode  out  1  mode of the issued job
- mm_matrix_1 / mm_matrix_2  out  N*N*W_IN  muxed operands
- mm_valid_out  in  1  mat_mul result valid
- mm_result  in  N*N*W_OUT  mat_mul result
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  requester owning the result
- rsp_result  out  N*N*W_OUT  result, passthrough of mm_result
- flush_req  in  1  request a drain
- flush_done  out  1  one-cycle pulse when drained
- inflight  out  $clog2(MAX_INFLIGHT)+1  current in-flight job count

Behaviour:
- Reset (rstn low, async) forces:
  - req_ready=0, mm_valid_in=0, mm_cen=1, rsp_valid=0, flush_done=0, inflight=0.
  - FIFO empty, RR pointer=0, state=RUN.
- Stall: `stall = mm_valid_out & ~rsp_ready`; `mm_cen = ~stall`. mat_mul holds valid_out and result while cen=0.
- rsp_valid = mm_valid_out. rsp_result = mm_result. rsp_id = FIFO head.
  - Pop occurs when mm_valid_out & rsp_ready.
  - mm_valid_out with an empty FIFO is a protocol error: assertion only, no recovery.
- Grant is combinational in the same cycle:
  - Grant is allowed when state=RUN, ~stall, and FIFO not full. If FIFO is full but a pop occurs this cycle, a grant is still allowed.
  - Winner is the first requester with valid, searching from the RR pointer upward modulo NUM_REQ.
  - req_ready is asserted only for the winner.
  - mm_valid_in = grant.
  - mm_mode and mm_matrix_* are muxed from the winner; they are zero when there is no grant.
  - Push the winner ID into the FIFO.
  - RR pointer advances to winner+1 on grant and holds otherwise.
- Latency: a request accepted in cycle t produces its result at t+L, where L is the mat_mul latency, plus any stall cycles. The scheduler adds zero latency.
- In-order: results leave in issue order, so the FIFO head is always correct.
- inflight = FIFO count.
  - Simultaneous push+pop leaves the count unchanged.
  - The count saturates at MAX_INFLIGHT because grant is blocked.
- State machine:
  - RUN → DRAIN when flush_req=1 (sampled at clock edge). No grants are made from that cycle on.
  - DRAIN → DONE when inflight==0 (including a pop this cycle that empties the FIFO).
  - DONE: flush_done=1 for exactly one cycle, then → RUN.
  - flush_req while in DRAIN or DONE is ignored.
  - A flush with inflight already 0 gives RUN → DRAIN → DONE: flush_done appears 2 cycles after flush_req.
- Reset mid-operation: all FIFO contents are lost. mat_mul must be reset by the same rstn; any results it has in flight are discarded.

Decomposition:
- Package mat_mul_pkg:
  - W_IN/W_OUT/N defaults
  - state enum {RUN, DRAIN, DONE}
  - matrix in/out typedefs
- Sub-module `sync_fifo` (parameters WIDTH=ID_W, DEPTH=MAX_INFLIGHT) with count output.
- Round-robin arbiter logic stays inline.

Test Plan:
- Single job: req_valid=01, A=I, B=all-2, mode=0 → req_ready=01 the same cycle; after L cycles rsp_valid=1, rsp_id=0, every element=2.
- Fairness: both requesters valid continuously for 8 cycles → grants alternate 0,1,0,1…; rsp_id sequence matches; 4 results each.
- Back-pressure: hold rsp_ready=0 when the first result arrives → mm_cen=0, req_ready=0, result stable; release → results resume in order with no loss or duplication.
- Full FIFO: MAX_INFLIGHT=4 with L=6 and continuous requests → inflight peaks at 4; grants pause until the first pop, then issue in the same cycle as the pop.
- Flush: flush_req with 3 jobs in flight → no grants; flush_done pulses once, 1 cycle after the last result pops; RUN resumes and grants the next cycle.
- Async reset: assert rstn=0 mid-stream between clock edges → outputs reach their reset values immediately; after release, inflight=0 and the first grant goes to requester 0.
